// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported unified memory between instruction fetch and MEM-stage data.
// Data accesses win by default; a streak counter forces a fetch grant after STARVE_MAX data wins.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              owner_if_q, owner_if_d;
    logic              kill_q, kill_d;
    logic [3:0]        d_streak_q, d_streak_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ready_q, if_ready_d;
    logic              d_ready_q, d_ready_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic grant_if;
    logic killed;

    assign grant_if = if_req & (~d_req | (d_streak_q == 4'(STARVE_MAX)));
    // A kill arriving in the same cycle as the ack still suppresses the response.
    assign killed   = kill_q | if_kill;

    always_comb begin
        state_d     = state_q;
        owner_if_d  = owner_if_q;
        kill_d      = kill_q;
        d_streak_d  = d_streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        case (state_q)
            S_IDLE: begin
                kill_d = 1'b0;
                if (if_req || d_req) begin
                    state_d    = S_BUSY;
                    mem_req_d  = 1'b1;
                    owner_if_d = grant_if;
                    if (grant_if) begin
                        mem_addr_d  = if_addr;
                        mem_we_d    = 1'b0;
                        mem_wdata_d = '0;
                        d_streak_d  = '0;
                    end else begin
                        mem_addr_d  = d_addr;
                        mem_we_d    = d_we;
                        mem_wdata_d = d_wdata;
                        if (!if_req)
                            d_streak_d = '0;
                        else if (d_streak_q != 4'hF)
                            d_streak_d = d_streak_q + 4'd1;
                    end
                end
            end
            S_BUSY: begin
                if (owner_if_q && if_kill)
                    kill_d = 1'b1;
                if (mem_ack) begin
                    state_d   = S_RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (owner_if_q) begin
                        if (!killed) begin
                            if_ready_d = 1'b1;
                            if_rdata_d = mem_rdata;
                        end
                    end else begin
                        d_ready_d = 1'b1;
                        if (!mem_we_q)
                            d_rdata_d = mem_rdata;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                kill_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            owner_if_q  <= 1'b0;
            kill_q      <= 1'b0;
            d_streak_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_if_q  <= owner_if_d;
            kill_q      <= kill_d;
            d_streak_q  <= d_streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ready  = if_ready_q;
    assign d_ready   = d_ready_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign stall_if  = if_req & ~if_ready_q;
    assign stall_mem = d_req & ~d_ready_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a behavioural memory with programmable wait states,
// expected read data queued at request time and popped on each ready pulse.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_kill, if_ready, d_req, d_we, d_ready;
    logic [15:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall_if, stall_mem, busy;

    int passed = 0;
    int total  = 0;

    logic [15:0] mem_arr [0:255];
    logic [15:0] if_exp[$];
    logic [15:0] d_exp[$];
    logic [15:0] obs[$];
    logic [15:0] last_if, last_d;
    int          mem_wait = 0;
    bit          mem_en   = 1'b1;
    int          wcnt     = 0;
    logic        mreq_prev = 1'b0;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(3)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory model: ack after mem_wait wait cycles, data driven with the ack.
    always @(negedge clk) begin
        if (mem_req && mem_en && !mem_ack) begin
            if (wcnt >= mem_wait) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_arr[mem_addr[7:0]];
                if (mem_we) mem_arr[mem_addr[7:0]] = mem_wdata;
                wcnt = 0;
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            if (!mem_req) wcnt = 0;
        end
    end

    // Records the address of each new grant in order.
    always @(negedge clk) begin
        if (mem_req && !mreq_prev) obs.push_back(mem_addr);
        mreq_prev = mem_req;
    end

    task automatic test_reset();
        reset = 1'b1; if_req = 0; if_kill = 0; if_addr = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        mem_ack = 0; mem_rdata = 0;
        #12;
        total++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got %b want 0", mem_req); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if ({if_ready, d_ready} !== 2'b00) $display("FAIL reset_ready got %b want 00", {if_ready, d_ready}); else passed++;
        total++; if ({if_rdata, d_rdata} !== 32'h0) $display("FAIL reset_rdata got %h want 0", {if_rdata, d_rdata}); else passed++;
        total++; if ({mem_we, mem_addr, mem_wdata} !== 33'h0) $display("FAIL reset_mem_bus got %h want 0", {mem_we, mem_addr, mem_wdata}); else passed++;
        @(negedge clk); reset = 1'b0;
        last_if = 16'h0; last_d = 16'h0;
    endtask

    task automatic test_if_fetch();
        logic [15:0] e;
        @(negedge clk);
        if_req = 1'b1; if_addr = 16'h0010; if_exp.push_back(mem_arr[8'h10]);
        @(negedge clk);
        total++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 16'h0010}) $display("FAIL fetch_grant got req=%b we=%b addr=%h want 1 0 0010", mem_req, mem_we, mem_addr); else passed++;
        total++; if (stall_if !== 1'b1) $display("FAIL fetch_stall got %b want 1", stall_if); else passed++;
        @(negedge clk);
        e = if_exp.pop_front();
        total++; if (if_ready !== 1'b1) $display("FAIL fetch_ready got %b want 1", if_ready); else passed++;
        total++; if (if_rdata !== e) $display("FAIL fetch_rdata got %h want %h", if_rdata, e); else passed++;
        total++; if (stall_if !== 1'b0) $display("FAIL fetch_stall_rdy got %b want 0", stall_if); else passed++;
        last_if = e; if_req = 1'b0;
        @(negedge clk);
        total++; if ({busy, if_ready} !== 2'b00) $display("FAIL fetch_idle got busy=%b rdy=%b want 0 0", busy, if_ready); else passed++;
    endtask

    task automatic test_simultaneous();
        logic [15:0] e;
        bit got_if = 0, got_d = 0, stall_ok = 1;
        obs.delete();
        @(negedge clk);
        if_req = 1'b1; if_addr = 16'h0020; if_exp.push_back(mem_arr[8'h20]);
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100; d_exp.push_back(mem_arr[8'h00]);
        for (int c = 0; c < 20 && !got_if; c++) begin
            @(negedge clk);
            if (d_ready) begin
                e = d_exp.pop_front(); got_d = 1; last_d = e; d_req = 1'b0;
                total++; if (d_rdata !== e) $display("FAIL sim_d_rdata got %h want %h", d_rdata, e); else passed++;
            end
            if (if_ready) begin
                e = if_exp.pop_front(); got_if = 1; last_if = e; if_req = 1'b0;
                total++; if (if_rdata !== e) $display("FAIL sim_if_rdata got %h want %h", if_rdata, e); else passed++;
            end else if (!stall_if) stall_ok = 0;
        end
        total++; if (!(got_d && got_if)) $display("FAIL sim_timeout got d=%0d if=%0d want 1 1", got_d, got_if); else passed++;
        total++; if (!stall_ok) $display("FAIL sim_stall_if got early drop want held"); else passed++;
        total++; if (obs.size() != 2 || obs[0] !== 16'h0100 || obs[1] !== 16'h0020)
            $display("FAIL sim_order got n=%0d first=%h want 2 grants 0100 then 0020", obs.size(), (obs.size() > 0) ? obs[0] : 16'hxxxx);
        else passed++;
    endtask

    task automatic test_starve();
        int ndr = 0, nir = 0;
        logic [15:0] exp_order [0:7];
        exp_order = '{16'h50, 16'h50, 16'h50, 16'h60, 16'h50, 16'h50, 16'h50, 16'h60};
        obs.delete(); mem_wait = 0;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0050;
        if_req = 1'b1; if_addr = 16'h0060;
        for (int c = 0; c < 60 && (ndr + nir) < 8; c++) begin
            @(negedge clk);
            if (d_ready) begin
                ndr++;
                total++; if (d_rdata !== mem_arr[8'h50]) $display("FAIL starve_d_rdata got %h want %h", d_rdata, mem_arr[8'h50]); else passed++;
            end
            if (if_ready) begin
                nir++;
                total++; if (if_rdata !== mem_arr[8'h60]) $display("FAIL starve_if_rdata got %h want %h", if_rdata, mem_arr[8'h60]); else passed++;
            end
            if (ndr + nir == 8) begin d_req = 1'b0; if_req = 1'b0; end
        end
        last_d = mem_arr[8'h50]; last_if = mem_arr[8'h60];
        total++; if (ndr != 6 || nir != 2) $display("FAIL starve_counts got d=%0d if=%0d want 6 2", ndr, nir); else passed++;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (i >= obs.size() || obs[i] !== exp_order[i])
                $display("FAIL starve_grant%0d got %h want %h", i, (i < obs.size()) ? obs[i] : 16'hxxxx, exp_order[i]);
            else passed++;
        end
    endtask

    task automatic test_store();
        int hold = 0, nrdy = 0;
        bit got = 0;
        mem_wait = 2;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'h1234;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (mem_req && mem_we && mem_wdata === 16'h1234 && mem_addr === 16'h0040) hold++;
            if (d_ready) begin nrdy++; d_req = 1'b0; d_we = 1'b0; end
        end
        total++; if (hold != 3) $display("FAIL store_hold got %0d want 3", hold); else passed++;
        total++; if (nrdy != 1) $display("FAIL store_ready_count got %0d want 1", nrdy); else passed++;
        total++; if (d_rdata !== last_d) $display("FAIL store_d_rdata got %h want %h", d_rdata, last_d); else passed++;
        mem_wait = 1;
        d_req = 1'b1; d_addr = 16'h0040;
        for (int c = 0; c < 12 && !got; c++) begin
            @(negedge clk);
            if (d_ready) begin
                got = 1; d_req = 1'b0; last_d = 16'h1234;
                total++; if (d_rdata !== 16'h1234) $display("FAIL store_readback got %h want 1234", d_rdata); else passed++;
            end
        end
        total++; if (!got) $display("FAIL store_readback_timeout got none want d_ready"); else passed++;
    endtask

    task automatic test_kill();
        int nrdy = 0;
        bit phase = 0, saw_idle = 0;
        obs.delete(); mem_wait = 1;
        @(negedge clk);
        if_req = 1'b1; if_addr = 16'h0070;
        @(negedge clk);
        if_kill = 1'b1;
        @(negedge clk);
        if_kill = 1'b0;
        for (int c = 0; c < 20 && nrdy == 0; c++) begin
            @(negedge clk);
            if (!busy) saw_idle = 1;
            if (if_ready) begin
                nrdy++; if_req = 1'b0; last_if = mem_arr[8'h30];
                total++; if (if_rdata !== mem_arr[8'h30]) $display("FAIL kill_next_rdata got %h want %h", if_rdata, mem_arr[8'h30]); else passed++;
            end else if (busy && !mem_req && !phase) begin
                phase = 1; if_addr = 16'h0030;
                total++; if (if_rdata !== last_if) $display("FAIL kill_rdata_kept got %h want %h", if_rdata, last_if); else passed++;
            end
        end
        total++; if (!phase || nrdy != 1) $display("FAIL kill_ready got resp=%0d readies=%0d want 1 1", phase, nrdy); else passed++;
        total++; if (!saw_idle) $display("FAIL kill_idle got never idle want idle"); else passed++;
        total++; if (obs.size() != 2 || obs[0] !== 16'h0070 || obs[1] !== 16'h0030)
            $display("FAIL kill_order got n=%0d want 2 grants 0070 then 0030", obs.size());
        else passed++;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        logic [15:0] exp_order [0:3];
        exp_order = '{16'h50, 16'h50, 16'h50, 16'h60};
        mem_wait = 0; mem_en = 1'b1;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0050;
        if_req = 1'b1; if_addr = 16'h0060;
        for (int c = 0; c < 30 && n < 2; c++) begin
            @(negedge clk);
            if (d_ready) n++;
            if (n == 2) mem_en = 1'b0;
        end
        repeat (3) @(negedge clk);
        total++; if ({mem_req, mem_addr} !== {1'b1, 16'h0050}) $display("FAIL mid_hang got req=%b addr=%h want 1 0050", mem_req, mem_addr); else passed++;
        #2 reset = 1'b1;
        #1;
        total++; if ({mem_req, busy, if_ready, d_ready, mem_we} !== 5'b0) $display("FAIL mid_reset got %b want 00000", {mem_req, busy, if_ready, d_ready, mem_we}); else passed++;
        obs.delete();
        @(negedge clk);
        reset = 1'b0; mem_en = 1'b1; n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (d_ready || if_ready) n++;
            if (n == 4) begin d_req = 1'b0; if_req = 1'b0; end
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= obs.size() || obs[i] !== exp_order[i])
                $display("FAIL mid_grant%0d got %h want %h", i, (i < obs.size()) ? obs[i] : 16'hxxxx, exp_order[i]);
            else passed++;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 16'hC000 | 16'(i);
        mem_arr[8'h10] = 16'hA5A5;
        test_reset();
        test_if_fetch();
        test_simultaneous();
        test_starve();
        test_store();
        test_kill();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
